// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the fetch-side branch machinery: branch-type encoding
// (common with the 2-bit direction predictor) and the sequential PC step.
package branch_target_buffer_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JUMP = 2'b10;

    localparam int unsigned PC_INC = 4;

    // 2'b11 is reserved and behaves like BR_NONE
    function automatic logic br_active(input logic [1:0] br);
        return (br == BR_COND) || (br == BR_JUMP);
    endfunction

endpackage

// File: rtl/btb_stat_counter.sv
// Saturating event counter with synchronous reset; sticks at all-ones.
module btb_stat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // count enabled events, holding once every bit is set
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup with the fetch PC,
// trained from EXE on taken branches/jumps, plus mispredict detection and
// branch / mispredict statistics.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32,
    parameter int CNT_BITS   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     if_pc,
    input  logic                if_dir_taken,
    output logic                if_hit,
    output logic                if_pred_taken,
    output logic [XLEN-1:0]     if_next_pc,
    input  logic [1:0]          exe_branch,
    input  logic [XLEN-1:0]     exe_pc,
    input  logic [XLEN-1:0]     exe_target,
    input  logic                exe_taken,
    input  logic                exe_pred_taken,
    input  logic [XLEN-1:0]     exe_pred_pc,
    output logic                mispredict,
    output logic [XLEN-1:0]     redirect_pc,
    output logic [CNT_BITS-1:0] branch_count,
    output logic [CNT_BITS-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    // Table storage; only the valid bits need a defined reset value
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag     [ENTRIES];
    logic [XLEN-1:0]    r_target  [ENTRIES];
    logic               r_is_jump [ENTRIES];

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_W-1:0]      w_if_tag;
    logic [INDEX_BITS-1:0] w_exe_idx;
    logic [TAG_W-1:0]      w_exe_tag;
    logic                  w_active;
    logic                  w_actual_taken;
    logic [XLEN-1:0]       w_actual_next;
    logic                  w_write;

    assign w_if_idx  = if_pc[INDEX_BITS+1:2];
    assign w_if_tag  = if_pc[XLEN-1:INDEX_BITS+2];
    assign w_exe_idx = exe_pc[INDEX_BITS+1:2];
    assign w_exe_tag = exe_pc[XLEN-1:INDEX_BITS+2];

    // Fetch-side lookup; reads pre-edge contents, no write bypass
    always_comb begin
        if_hit        = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        if_pred_taken = if_hit && (r_is_jump[w_if_idx] || if_dir_taken);
        if_next_pc    = if_pred_taken ? r_target[w_if_idx]
                                      : if_pc + XLEN'(PC_INC);
    end

    // Resolve the EXE outcome against the prediction carried down the pipe
    always_comb begin
        w_active       = br_active(exe_branch);
        w_actual_taken = (exe_branch == BR_JUMP) || exe_taken;
        w_actual_next  = w_actual_taken ? exe_target : exe_pc + XLEN'(PC_INC);
        mispredict     = 1'b0;
        redirect_pc    = '0;
        if (w_active) begin
            mispredict  = (w_actual_taken != exe_pred_taken) ||
                          (w_actual_next != exe_pred_pc);
            redirect_pc = w_actual_next;
        end
    end

    // Only taken outcomes train the table; not-taken leaves the entry alone
    assign w_write = w_active && w_actual_taken;

    // Valid bits: cleared on reset, set when an entry is installed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_write) begin
            r_valid[w_exe_idx] <= 1'b1;
        end
    end

    // Entry payload: overwrite any alias; suppressed while in reset
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_tag[w_exe_idx]     <= w_exe_tag;
            r_target[w_exe_idx]  <= exe_target;
            r_is_jump[w_exe_idx] <= (exe_branch == BR_JUMP);
        end
    end

    btb_stat_counter #(.W(CNT_BITS)) u_branch_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_active),
        .o_count (branch_count)
    );

    btb_stat_counter #(.W(CNT_BITS)) u_mispredict_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (mispredict),
        .o_count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Table-driven bench for branch_target_buffer. Each vector is held for one
// cycle; its expected outputs go into a queue when driven and are popped and
// compared on the following falling edge. Counters are narrowed to 3 bits so
// saturation is reachable.
module tb_branch_target_buffer;

    localparam int XLEN = 32;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] if_pc;
    logic            if_dir_taken;
    logic            if_hit;
    logic            if_pred_taken;
    logic [XLEN-1:0] if_next_pc;
    logic [1:0]      exe_branch;
    logic [XLEN-1:0] exe_pc;
    logic [XLEN-1:0] exe_target;
    logic            exe_taken;
    logic            exe_pred_taken;
    logic [XLEN-1:0] exe_pred_pc;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   branch_count;
    logic [CW-1:0]   mispredict_count;

    always #5 clk = ~clk;

    branch_target_buffer #(.INDEX_BITS(4), .XLEN(XLEN), .CNT_BITS(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_dir_taken     (if_dir_taken),
        .if_hit           (if_hit),
        .if_pred_taken    (if_pred_taken),
        .if_next_pc       (if_next_pc),
        .exe_branch       (exe_branch),
        .exe_pc           (exe_pc),
        .exe_target       (exe_target),
        .exe_taken        (exe_taken),
        .exe_pred_taken   (exe_pred_taken),
        .exe_pred_pc      (exe_pred_pc),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic            rst;
        logic [XLEN-1:0] pc;
        logic            dir;
        logic [1:0]      br;
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] etgt;
        logic            etk;
        logic            eptk;
        logic [XLEN-1:0] eppc;
        logic            hit;
        logic            pt;
        logic [XLEN-1:0] npc;
        logic            mp;
        logic [XLEN-1:0] rd;
        logic [CW-1:0]   bc;
        logic [CW-1:0]   mc;
    } vec_t;

    typedef struct {
        int   id;
        vec_t v;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    function automatic vec_t mk(
        input logic r, input logic [31:0] pc, input logic dir,
        input logic [1:0] br, input logic [31:0] epc, input logic [31:0] etgt,
        input logic etk, input logic eptk, input logic [31:0] eppc,
        input logic hit, input logic pt, input logic [31:0] npc,
        input logic mp, input logic [31:0] rd, input int bc, input int mc);
        vec_t v;
        v.rst = r;   v.pc = pc;     v.dir = dir;  v.br = br;
        v.epc = epc; v.etgt = etgt; v.etk = etk;  v.eptk = eptk; v.eppc = eppc;
        v.hit = hit; v.pt = pt;     v.npc = npc;  v.mp = mp;     v.rd = rd;
        v.bc = CW'(bc); v.mc = CW'(mc);
        return v;
    endfunction

    task automatic chk(input int id, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, name, act, exp);
        end
    endtask

    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst = v.rst; if_pc = v.pc; if_dir_taken = v.dir;
        exe_branch = v.br; exe_pc = v.epc; exe_target = v.etgt;
        exe_taken = v.etk; exe_pred_taken = v.eptk; exe_pred_pc = v.eppc;
        e.id = id; e.v = v;
        sb_q.push_back(e);
    endtask

    // Scoreboard: compare DUT outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.id, "if_hit",           32'(if_hit),           32'(e.v.hit));
            chk(e.id, "if_pred_taken",    32'(if_pred_taken),    32'(e.v.pt));
            chk(e.id, "if_next_pc",       if_next_pc,            e.v.npc);
            chk(e.id, "mispredict",       32'(mispredict),       32'(e.v.mp));
            chk(e.id, "redirect_pc",      redirect_pc,           e.v.rd);
            chk(e.id, "branch_count",     32'(branch_count),     32'(e.v.bc));
            chk(e.id, "mispredict_count", 32'(mispredict_count), 32'(e.v.mc));
        end
    end

    localparam logic [1:0] N = 2'b00, C = 2'b01, J = 2'b10, R = 2'b11;

    vec_t tbl[19];

    initial begin
        //            rst pc            dir br epc     etgt   tk ptk ppc      hit pt npc          mp rd      bc mc
        tbl[0]  = mk(0, 32'h100,        0, N, 0,       0,     0, 0, 0,       0, 0, 32'h104,     0, 0,       0, 0);
        tbl[1]  = mk(0, 32'h100,        1, C, 32'h100, 32'h80,1, 0, 32'h104, 0, 0, 32'h104,     1, 32'h80,  0, 0);
        tbl[2]  = mk(0, 32'h100,        1, N, 0,       0,     0, 0, 0,       1, 1, 32'h80,      0, 0,       1, 1);
        tbl[3]  = mk(0, 32'h100,        0, N, 0,       0,     0, 0, 0,       1, 0, 32'h104,     0, 0,       1, 1);
        tbl[4]  = mk(0, 32'h100,        1, C, 32'h100, 32'h80,1, 1, 32'h80,  1, 1, 32'h80,      0, 32'h80,  1, 1);
        tbl[5]  = mk(0, 32'h104,        1, C, 32'h100, 32'h90,1, 1, 32'h80,  0, 0, 32'h108,     1, 32'h90,  2, 1);
        tbl[6]  = mk(0, 32'h100,        1, C, 32'h100, 32'h90,0, 1, 32'h90,  1, 1, 32'h90,      1, 32'h104, 3, 2);
        tbl[7]  = mk(0, 32'h100,        1, N, 0,       0,     0, 0, 0,       1, 1, 32'h90,      0, 0,       4, 3);
        tbl[8]  = mk(0, 32'h140,        1, C, 32'h140, 32'h500,1,0, 32'h144, 0, 0, 32'h144,     1, 32'h500, 4, 3);
        tbl[9]  = mk(0, 32'h100,        1, N, 0,       0,     0, 0, 0,       0, 0, 32'h104,     0, 0,       5, 4);
        tbl[10] = mk(0, 32'h140,        1, N, 0,       0,     0, 0, 0,       1, 1, 32'h500,     0, 0,       5, 4);
        tbl[11] = mk(0, 32'h140,        0, J, 32'h200, 32'h400,0,0, 32'h204, 1, 0, 32'h144,     1, 32'h400, 5, 4);
        tbl[12] = mk(0, 32'h200,        0, R, 32'h300, 32'h10,1, 0, 0,       1, 1, 32'h400,     0, 0,       6, 5);
        tbl[13] = mk(0, 32'h300,        1, J, 32'h60C, 32'h20,0, 1, 32'h20,  0, 0, 32'h304,     0, 32'h20,  6, 5);
        tbl[14] = mk(0, 32'h60C,        0, C, 32'h60C, 32'h20,1, 0, 32'h610, 1, 1, 32'h20,      1, 32'h20,  7, 5);
        tbl[15] = mk(0, 32'h60C,        0, C, 32'h700, 32'h44,0, 0, 32'h704, 1, 0, 32'h610,     0, 32'h704, 7, 6);
        tbl[16] = mk(0, 32'hFFFF_FFFC,  1, C, 32'h710, 32'h0, 1, 0, 32'h714, 0, 0, 32'h0,       1, 32'h0,   7, 6);
        tbl[17] = mk(0, 32'h710,        1, C, 32'h714, 32'h8, 1, 0, 32'h718, 1, 1, 32'h0,       1, 32'h8,   7, 7);
        tbl[18] = mk(0, 32'h714,        1, N, 0,       0,     0, 0, 0,       1, 1, 32'h8,       0, 0,       7, 7);

        rst = 1'b1; if_pc = '0; if_dir_taken = 1'b0;
        exe_branch = N; exe_pc = '0; exe_target = '0;
        exe_taken = 1'b0; exe_pred_taken = 1'b0; exe_pred_pc = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) apply(i, tbl[i]);

        // Reset arriving with a taken update at 0x300: update is lost, the
        // lookup in the reset cycle still sees old contents, everything
        // is empty afterwards.
        apply(19, mk(1, 32'h714, 1, C, 32'h300, 32'h900, 1, 0, 32'h304,
                     1, 1, 32'h8, 1, 32'h900, 7, 7));
        apply(20, mk(0, 32'h300, 1, N, 0, 0, 0, 0, 0,
                     0, 0, 32'h304, 0, 0, 0, 0));
        apply(21, mk(0, 32'h714, 1, N, 0, 0, 0, 0, 0,
                     0, 0, 32'h718, 0, 0, 0, 0));

        // Write and lookup of the same index in one cycle: old data, then new
        apply(22, mk(0, 32'h300, 1, J, 32'h300, 32'hA0, 0, 0, 32'h304,
                     0, 0, 32'h304, 1, 32'hA0, 0, 0));
        apply(23, mk(0, 32'h300, 0, N, 0, 0, 0, 0, 0,
                     1, 1, 32'hA0, 0, 0, 1, 1));

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
